// File: rtl/maxterm_scanner_if.sv
// maxterm_scanner_if: valid/ready stream carrying maxterm indices.
//   m_valid  - an index is presented (driven by master)
//   m_index  - presented maxterm index, N bits (driven by master)
//   m_last   - presented index is the final maxterm (driven by master)
//   m_ready  - consumer accepts the presented index (driven by slave)
interface maxterm_scanner_if #(
    parameter int N = 4
) ();
    logic         m_valid;
    logic [N-1:0] m_index;
    logic         m_last;
    logic         m_ready;

    modport master (output m_valid, output m_index, output m_last, input m_ready);
    modport slave  (input m_valid, input m_index, input m_last, output m_ready);
endinterface

// File: rtl/maxterm_scanner.sv
// maxterm_scanner: walks an external N-input function through every input
// vector in ascending order, records each index where it evaluates to 0,
// then reports the maxterm mask/count and streams the indices out.
//   clk          - rising-edge clock
//   rst_n        - asynchronous active-low reset
//   start        - begin a scan (honoured only in IDLE)
//   f_in         - output of the function under test
//   vec_out      - input vector driven to the function (index = vec_out)
//   busy         - high while scanning or emitting
//   done         - one-cycle pulse when a run completes
//   maxterm_mask - bit i set iff f(i) = 0; held until the next start
//   max_count    - number of set bits in maxterm_mask
//   m            - maxterm index stream (master side)
module maxterm_scanner #(
    parameter int N      = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 f_in,
    output logic [N-1:0]         vec_out,
    output logic                 busy,
    output logic                 done,
    output logic [(1<<N)-1:0]    maxterm_mask,
    output logic [N:0]           max_count,
    maxterm_scanner_if.master    m
);
    localparam int unsigned W  = 1 << N;
    localparam int unsigned CW = N + 1;

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

    state_t         state, state_nxt;
    logic [3:0]     settle_cnt;
    logic [W-1:0]   pend;
    logic           sample;
    logic           last_vec;
    logic [W-1:0]   mask_nxt;
    logic [W-1:0]   pend_clr;
    logic [CW-1:0]  count_nxt;

    function automatic logic [N-1:0] lowest_set(input logic [W-1:0] v);
        logic [N-1:0] idx;
        logic         found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (v[i] && !found) begin
                idx   = N'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    // v & (v-1) drops the lowest set bit; empty result means nothing above it
    function automatic logic at_most_one(input logic [W-1:0] v);
        return (v & (v - W'(1))) == '0;
    endfunction

    assign sample    = (state == SCAN) && (settle_cnt == 4'(SETTLE - 1));
    assign last_vec  = (vec_out == '1);
    // Mask/count as they will be after the current sample, so the final
    // sample is already included when choosing EMIT vs DONE.
    assign mask_nxt  = maxterm_mask | (W'(!f_in) << vec_out);
    assign count_nxt = max_count + CW'(!f_in);
    assign pend_clr  = pend & ~(W'(1) << m.m_index);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = SCAN;
            SCAN: if (sample && last_vec) state_nxt = (count_nxt != '0) ? EMIT : DONE;
            EMIT: if (m.m_ready && m.m_last) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy      = (state == SCAN) || (state == EMIT);
        done      = (state == DONE);
        m.m_valid = (state == EMIT);
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_out      <= '0;
            settle_cnt   <= '0;
            maxterm_mask <= '0;
            max_count    <= '0;
            pend         <= '0;
            m.m_index    <= '0;
            m.m_last     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        vec_out      <= '0;
                        settle_cnt   <= '0;
                        maxterm_mask <= '0;
                        max_count    <= '0;
                        pend         <= '0;
                    end
                end
                SCAN: begin
                    if (sample) begin
                        maxterm_mask <= mask_nxt;
                        max_count    <= count_nxt;
                        vec_out      <= vec_out + N'(1);
                        settle_cnt   <= '0;
                        if (last_vec) begin
                            // Emission works on a private copy so the
                            // reported mask stays intact.
                            pend      <= mask_nxt;
                            m.m_index <= lowest_set(mask_nxt);
                            m.m_last  <= at_most_one(mask_nxt) && (mask_nxt != '0);
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                EMIT: begin
                    if (m.m_ready) begin
                        pend <= pend_clr;
                        if (m.m_last) begin
                            m.m_index <= '0;
                            m.m_last  <= 1'b0;
                        end else begin
                            m.m_index <= lowest_set(pend_clr);
                            m.m_last  <= at_most_one(pend_clr);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
